// File: rtl/im2col_addr_gen.sv
// im2col byte-address generator: nested window/channel/kernel counters, 3-stage pipe, first addr_valid 3 cycles after start.
// addr_valid && !addr_ready freezes all occupied stages and the counters. Optional clamp output under IM2COL_CLAMP_ADDR_EN.
module im2col_addr_gen #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DIM_W     = 8,
  parameter int                 CH_W      = 10,
  parameter int                 ELEM_LOG2 = 2,
  parameter logic [ADDR_W-1:0]  PAD_ADDR  = ADDR_W'(32'h0000_0FFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_image_addr,
  input  logic [DIM_W-1:0]  cfg_image_h,
  input  logic [DIM_W-1:0]  cfg_image_w,
  input  logic [CH_W-1:0]   cfg_num_ch,
  input  logic [3:0]        cfg_ksize,
  input  logic [3:0]        cfg_stride,
  input  logic [1:0]        cfg_pad,
  input  logic [DIM_W-1:0]  cfg_out_h,
  input  logic [DIM_W-1:0]  cfg_out_w,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_pad,
  output logic              addr_last,
  output logic [ADDR_W-1:0] addr_clamp,
  output logic              busy,
  output logic              done
);

  localparam int CW = DIM_W + 6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_image_addr;
  logic [DIM_W-1:0]  r_image_h, r_image_w, r_out_h, r_out_w;
  logic [CH_W-1:0]   r_num_ch;
  logic [3:0]        r_ksize, r_stride;
  logic [1:0]        r_pad;

  // Stage 1: the loop counters themselves
  logic              r_s1_vld;
  logic [DIM_W-1:0]  r_oy, r_ox;
  logic [CH_W-1:0]   r_c;
  logic [3:0]        r_ky, r_kx;

  // Stage 2: coordinates and range flag
  logic              r_s2_vld, r_s2_pad, r_s2_last;
  logic [CH_W-1:0]   r_s2_c;
  logic [DIM_W-1:0]  r_s2_iy, r_s2_ix;

  // Stage 3: output register
  logic              r_s3_vld, r_s3_pad, r_s3_last;
  logic [ADDR_W-1:0] r_addr;

  logic w_zero_cfg, w_start_go;
  logic w_kx_end, w_ky_end, w_c_end, w_ox_end, w_oy_end, w_all_end;
  logic w_xfer, w_s3_en, w_s2_en, w_s1_adv;
  logic [CW-1:0]     w_iy, w_ix;
  logic              w_iy_oor, w_ix_oor;
  logic [DIM_W-1:0]  w_iy_sel, w_ix_sel;
  logic [ADDR_W-1:0] w_lin, w_elem_addr;

  assign w_zero_cfg = (cfg_ksize == 4'd0) || (cfg_num_ch == '0) ||
                      (cfg_out_h == '0) || (cfg_out_w == '0);
  assign w_start_go = (r_state == S_IDLE) && start;

  assign w_kx_end  = (r_kx == r_ksize - 4'd1);
  assign w_ky_end  = (r_ky == r_ksize - 4'd1);
  assign w_c_end   = (r_c  == r_num_ch - CH_W'(1));
  assign w_ox_end  = (r_ox == r_out_w - DIM_W'(1));
  assign w_oy_end  = (r_oy == r_out_h - DIM_W'(1));
  assign w_all_end = w_kx_end && w_ky_end && w_c_end && w_ox_end && w_oy_end;

  // Each stage moves when it is empty or the stage below moves, so bubbles collapse.
  assign w_xfer   = r_s3_vld && addr_ready;
  assign w_s3_en  = !r_s3_vld || addr_ready;
  assign w_s2_en  = !r_s2_vld || w_s3_en;
  assign w_s1_adv = r_s1_vld && w_s2_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_image_addr <= '0;
      r_image_h    <= '0;
      r_image_w    <= '0;
      r_num_ch     <= '0;
      r_ksize      <= '0;
      r_stride     <= '0;
      r_pad        <= '0;
      r_out_h      <= '0;
      r_out_w      <= '0;
    end else if (w_start_go) begin
      r_image_addr <= cfg_image_addr;
      r_image_h    <= cfg_image_h;
      r_image_w    <= cfg_image_w;
      r_num_ch     <= cfg_num_ch;
      r_ksize      <= cfg_ksize;
      r_stride     <= cfg_stride;
      r_pad        <= cfg_pad;
      r_out_h      <= cfg_out_h;
      r_out_w      <= cfg_out_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
      r_oy     <= '0;
      r_ox     <= '0;
      r_c      <= '0;
      r_ky     <= '0;
      r_kx     <= '0;
    end else if (w_start_go) begin
      r_s1_vld <= !w_zero_cfg;
      r_oy     <= '0;
      r_ox     <= '0;
      r_c      <= '0;
      r_ky     <= '0;
      r_kx     <= '0;
    end else if (w_s1_adv) begin
      if (w_all_end) r_s1_vld <= 1'b0;
      r_kx <= w_kx_end ? '0 : r_kx + 4'd1;
      if (w_kx_end)
        r_ky <= w_ky_end ? '0 : r_ky + 4'd1;
      if (w_kx_end && w_ky_end)
        r_c <= w_c_end ? '0 : r_c + CH_W'(1);
      if (w_kx_end && w_ky_end && w_c_end)
        r_ox <= w_ox_end ? '0 : r_ox + DIM_W'(1);
      if (w_kx_end && w_ky_end && w_c_end && w_ox_end)
        r_oy <= w_oy_end ? '0 : r_oy + DIM_W'(1);
    end
  end

  // Two's-complement coordinates; the MSB is the sign.
  assign w_iy = CW'(r_oy) * CW'(r_stride) + CW'(r_ky) - CW'(r_pad);
  assign w_ix = CW'(r_ox) * CW'(r_stride) + CW'(r_kx) - CW'(r_pad);
  assign w_iy_oor = w_iy[CW-1] || (w_iy[CW-2:0] >= (CW-1)'(r_image_h));
  assign w_ix_oor = w_ix[CW-1] || (w_ix[CW-2:0] >= (CW-1)'(r_image_w));

`ifdef IM2COL_CLAMP_ADDR_EN
  // In range the clamped value equals the raw one, so one address path serves both outputs.
  assign w_iy_sel = w_iy[CW-1] ? '0 : (w_iy_oor ? r_image_h - DIM_W'(1) : w_iy[DIM_W-1:0]);
  assign w_ix_sel = w_ix[CW-1] ? '0 : (w_ix_oor ? r_image_w - DIM_W'(1) : w_ix[DIM_W-1:0]);
`else
  assign w_iy_sel = w_iy[DIM_W-1:0];
  assign w_ix_sel = w_ix[DIM_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_pad  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_c    <= '0;
      r_s2_iy   <= '0;
      r_s2_ix   <= '0;
    end else if (w_s2_en) begin
      r_s2_vld  <= r_s1_vld;
      r_s2_pad  <= r_s1_vld && (w_iy_oor || w_ix_oor);
      r_s2_last <= r_s1_vld && w_all_end;
      r_s2_c    <= r_c;
      r_s2_iy   <= w_iy_sel;
      r_s2_ix   <= w_ix_sel;
    end
  end

  assign w_lin = (ADDR_W'(r_s2_c) * ADDR_W'(r_image_h) + ADDR_W'(r_s2_iy)) * ADDR_W'(r_image_w)
               + ADDR_W'(r_s2_ix);
  assign w_elem_addr = r_image_addr + (w_lin << ELEM_LOG2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s3_vld  <= 1'b0;
      r_s3_pad  <= 1'b0;
      r_s3_last <= 1'b0;
      r_addr    <= '0;
    end else if (w_s3_en) begin
      r_s3_vld  <= r_s2_vld;
      r_s3_pad  <= r_s2_vld && r_s2_pad;
      r_s3_last <= r_s2_vld && r_s2_last;
      r_addr    <= r_s2_pad ? PAD_ADDR : w_elem_addr;
    end
  end

`ifdef IM2COL_CLAMP_ADDR_EN
  logic [ADDR_W-1:0] r_addr_clamp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_clamp <= '0;
    end else if (w_s3_en) begin
      r_addr_clamp <= w_elem_addr;
    end
  end

  assign addr_clamp = r_addr_clamp;
`else
  assign addr_clamp = '0;
`endif

  assign addr_valid = r_s3_vld;
  assign addr       = r_addr;
  assign addr_pad   = r_s3_pad;
  assign addr_last  = r_s3_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = w_zero_cfg ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_s1_adv && w_all_end) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_xfer && r_s3_last) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_im2col_addr_gen.sv
// Directed bench for im2col_addr_gen: stream order, padding, channels, stalls, zero config, restart, reset and clamp output.
module tb_im2col_addr_gen;
  localparam int DIM_W = 8;
  localparam int CH_W  = 10;
  localparam logic [31:0] PADV = 32'h0000_0FFF;

  logic        clk, rst, start;
  logic [31:0] cfg_image_addr;
  logic [7:0]  cfg_image_h, cfg_image_w, cfg_out_h, cfg_out_w;
  logic [9:0]  cfg_num_ch;
  logic [3:0]  cfg_ksize, cfg_stride;
  logic [1:0]  cfg_pad;
  logic        addr_valid, addr_ready, addr_pad, addr_last, busy, done;
  logic [31:0] addr, addr_clamp;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_addr[$];
  logic        got_pad[$];
  logic        got_last[$];
  logic [31:0] got_clamp[$];
  logic [31:0] exp_addr[$];
  logic        exp_pad[$];

  int          n_acc, done_cnt, last_cyc, done_cyc, first_vld_cyc, hold_err;
  logic        timed_out, busy_at_done, seen_valid;
  logic [31:0] held_addr;

  im2col_addr_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_image_addr(cfg_image_addr), .cfg_image_h(cfg_image_h), .cfg_image_w(cfg_image_w),
    .cfg_num_ch(cfg_num_ch), .cfg_ksize(cfg_ksize), .cfg_stride(cfg_stride), .cfg_pad(cfg_pad),
    .cfg_out_h(cfg_out_h), .cfg_out_w(cfg_out_w),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr), .addr_pad(addr_pad),
    .addr_last(addr_last), .addr_clamp(addr_clamp), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_cfg(input logic [31:0] base, input int h, w, ch, k, s, p, oh, ow);
    cfg_image_addr = base;
    cfg_image_h    = DIM_W'(h);
    cfg_image_w    = DIM_W'(w);
    cfg_num_ch     = CH_W'(ch);
    cfg_ksize      = 4'(k);
    cfg_stride     = 4'(s);
    cfg_pad        = 2'(p);
    cfg_out_h      = DIM_W'(oh);
    cfg_out_w      = DIM_W'(ow);
  endtask

  // Reference stream straight from the loop nest and coordinate formula.
  task automatic build_exp(input logic [31:0] base, input int h, w, ch, k, s, p, oh, ow);
    exp_addr.delete();
    exp_pad.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int c = 0; c < ch; c++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              int iy, ix;
              iy = oy * s + ky - p;
              ix = ox * s + kx - p;
              if (iy < 0 || ix < 0 || iy >= h || ix >= w) begin
                exp_addr.push_back(PADV);
                exp_pad.push_back(1'b1);
              end else begin
                exp_addr.push_back(base + 32'(((c * h + iy) * w + ix) * 4));
                exp_pad.push_back(1'b0);
              end
            end
  endtask

  task automatic start_job();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Drives addr_ready and records accepted elements until done, stop_n elements, or the budget runs out.
  task automatic collect(input int stall_at, input int stall_len, input int restart_at,
                         input int stop_n, input int budget);
    int stalled;
    logic restarted;
    got_addr.delete(); got_pad.delete(); got_last.delete(); got_clamp.delete();
    n_acc = 0; done_cnt = 0; last_cyc = -1; done_cyc = -1; first_vld_cyc = -1; hold_err = 0;
    timed_out = 1'b1; busy_at_done = 1'b1; seen_valid = 1'b0; held_addr = '0;
    stalled = 0; restarted = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart_at >= 0 && n_acc == restart_at && !restarted) begin
        start          = 1'b1;
        cfg_image_addr = 32'h0000_2000;
        restarted      = 1'b1;
      end
      if (stall_at >= 0 && n_acc == stall_at && stalled < stall_len) begin
        addr_ready = 1'b0;
        stalled++;
      end else begin
        addr_ready = 1'b1;
      end
      #1;
      if (addr_valid) begin
        seen_valid = 1'b1;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (!addr_ready) begin
        if (stalled == 1) held_addr = addr;
        if (!addr_valid || addr !== held_addr) hold_err++;
      end
      if (addr_valid && addr_ready) begin
        got_addr.push_back(addr);
        got_pad.push_back(addr_pad);
        got_last.push_back(addr_last);
        got_clamp.push_back(addr_clamp);
        n_acc++;
        if (addr_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (done || (stop_n > 0 && n_acc >= stop_n)) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; addr_ready = 1'b1;
    set_cfg(32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", addr_valid); end
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", addr); end
    total++; if ({addr_pad, addr_last, busy, done} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {addr_pad, addr_last, busy, done}); end
    total++; if (addr_clamp !== 32'h0) begin bad++; $display("FAIL reset_clamp: got %h want 0", addr_clamp); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    set_cfg(32'h1000, 4, 4, 1, 3, 1, 0, 2, 2);
    build_exp(32'h1000, 4, 4, 1, 3, 1, 0, 2, 2);
    start_job();
    collect(-1, 0, -1, 0, 400);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
    total++; if (first_vld_cyc !== 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", first_vld_cyc); end
    total++; if (n_acc !== 36) begin bad++; $display("FAIL basic_count: got %0d want 36", n_acc); end
    if (n_acc == 36) begin
      total++; if (got_addr[0] !== 32'h1000) begin bad++; $display("FAIL basic_e1: got %h want 1000", got_addr[0]); end
      total++; if (got_addr[1] !== 32'h1004) begin bad++; $display("FAIL basic_e2: got %h want 1004", got_addr[1]); end
      total++; if (got_addr[2] !== 32'h1008) begin bad++; $display("FAIL basic_e3: got %h want 1008", got_addr[2]); end
      total++; if (got_addr[3] !== 32'h1010) begin bad++; $display("FAIL basic_e4: got %h want 1010", got_addr[3]); end
      total++; if (got_addr[35] !== 32'h103C || got_last[35] !== 1'b1) begin bad++; $display("FAIL basic_last: got %h/%b want 103c/1", got_addr[35], got_last[35]); end
      for (int i = 0; i < 36; i++) begin
        total++;
        if (got_addr[i] !== exp_addr[i] || got_pad[i] !== exp_pad[i] || got_last[i] !== (i == 35)) begin
          bad++; $display("FAIL basic_stream[%0d]: got %h/%b/%b want %h/%b/%b", i, got_addr[i], got_pad[i], got_last[i], exp_addr[i], exp_pad[i], i == 35);
        end
      end
    end
    total++; if (done_cyc !== last_cyc + 1) begin bad++; $display("FAIL basic_done_timing: got cyc %0d want %0d", done_cyc, last_cyc + 1); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
    @(negedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_padding();
    set_cfg(32'h1000, 4, 4, 1, 3, 1, 1, 4, 4);
    build_exp(32'h1000, 4, 4, 1, 3, 1, 1, 4, 4);
    start_job();
    collect(-1, 0, -1, 0, 600);
    total++; if (n_acc !== 144) begin bad++; $display("FAIL pad_count: got %0d want 144", n_acc); end
    if (n_acc == 144) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_addr[i] !== PADV || got_pad[i] !== 1'b1) begin bad++; $display("FAIL pad_e%0d: got %h/%b want %h/1", i + 1, got_addr[i], got_pad[i], PADV); end
      end
      total++; if (got_addr[4] !== 32'h1000 || got_pad[4] !== 1'b0) begin bad++; $display("FAIL pad_e5: got %h/%b want 1000/0", got_addr[4], got_pad[4]); end
      for (int i = 0; i < 144; i++) begin
        total++;
        if (got_addr[i] !== exp_addr[i] || got_pad[i] !== exp_pad[i] || got_last[i] !== (i == 143)) begin
          bad++; $display("FAIL pad_stream[%0d]: got %h/%b/%b want %h/%b", i, got_addr[i], got_pad[i], got_last[i], exp_addr[i], exp_pad[i]);
        end
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL pad_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_multichannel();
    set_cfg(32'h1000, 4, 4, 2, 1, 1, 0, 1, 1);
    start_job();
    collect(-1, 0, -1, 0, 100);
    total++; if (n_acc !== 2) begin bad++; $display("FAIL mch_count: got %0d want 2", n_acc); end
    if (n_acc == 2) begin
      total++; if (got_addr[0] !== 32'h1000 || got_last[0] !== 1'b0) begin bad++; $display("FAIL mch_e1: got %h/%b want 1000/0", got_addr[0], got_last[0]); end
      total++; if (got_addr[1] !== 32'h1040 || got_last[1] !== 1'b1) begin bad++; $display("FAIL mch_e2: got %h/%b want 1040/1", got_addr[1], got_last[1]); end
    end
  endtask

  task automatic test_backpressure();
    set_cfg(32'h1000, 4, 4, 1, 3, 1, 0, 2, 2);
    build_exp(32'h1000, 4, 4, 1, 3, 1, 0, 2, 2);
    start_job();
    collect(10, 5, -1, 0, 400);
    total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_err); end
    total++; if (held_addr !== 32'h1008) begin bad++; $display("FAIL bp_held_addr: got %h want 1008", held_addr); end
    total++; if (n_acc !== 36) begin bad++; $display("FAIL bp_count: got %0d want 36", n_acc); end
    if (n_acc == 36) begin
      for (int i = 0; i < 36; i++) begin
        total++;
        if (got_addr[i] !== exp_addr[i] || got_last[i] !== (i == 35)) begin
          bad++; $display("FAIL bp_stream[%0d]: got %h/%b want %h", i, got_addr[i], got_last[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_zero_restart();
    set_cfg(32'h1000, 4, 4, 1, 0, 1, 0, 2, 2);
    start_job();
    collect(-1, 0, -1, 0, 20);
    total++; if (done_cnt !== 1 || timed_out !== 1'b0) begin bad++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt); end
    total++; if (seen_valid !== 1'b0) begin bad++; $display("FAIL zero_no_valid: got %b want 0", seen_valid); end
    set_cfg(32'h1000, 4, 4, 1, 3, 1, 0, 2, 2);
    build_exp(32'h1000, 4, 4, 1, 3, 1, 0, 2, 2);
    start_job();
    collect(-1, 0, 5, 0, 400);
    total++; if (n_acc !== 36 || done_cnt !== 1) begin bad++; $display("FAIL restart_count: got %0d/%0d want 36/1", n_acc, done_cnt); end
    if (n_acc == 36) begin
      for (int i = 0; i < 36; i++) begin
        total++;
        if (got_addr[i] !== exp_addr[i]) begin bad++; $display("FAIL restart_stream[%0d]: got %h want %h", i, got_addr[i], exp_addr[i]); end
      end
    end
  endtask

  task automatic test_reset_midjob();
    set_cfg(32'h1000, 4, 4, 1, 3, 1, 0, 2, 2);
    start_job();
    collect(-1, 0, -1, 20, 400);
    total++; if (n_acc !== 20) begin bad++; $display("FAIL rmid_reach: got %0d want 20", n_acc); end
    rst = 1'b0;
    #1;
    total++; if ({addr_valid, addr_pad, addr_last, busy, done} !== 5'b0) begin bad++; $display("FAIL rmid_flags: got %b want 00000", {addr_valid, addr_pad, addr_last, busy, done}); end
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL rmid_addr: got %h want 0", addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_no_done: got %b want 0", done); end
    end
    @(negedge clk);
    rst = 1'b1;
    start_job();
    collect(-1, 0, -1, 0, 400);
    total++; if (n_acc !== 36 || done_cnt !== 1) begin bad++; $display("FAIL rmid_replay_count: got %0d/%0d want 36/1", n_acc, done_cnt); end
    if (n_acc == 36) begin
      total++; if (got_addr[0] !== 32'h1000) begin bad++; $display("FAIL rmid_replay_first: got %h want 1000", got_addr[0]); end
    end
  endtask

  task automatic test_clamp();
    logic [31:0] exp_c0, exp_c2, exp_c4;
`ifdef IM2COL_CLAMP_ADDR_EN
    exp_c0 = 32'h1000; exp_c2 = 32'h1004; exp_c4 = 32'h1000;
`else
    exp_c0 = 32'h0; exp_c2 = 32'h0; exp_c4 = 32'h0;
`endif
    set_cfg(32'h1000, 4, 4, 1, 3, 1, 1, 4, 4);
    start_job();
    collect(-1, 0, -1, 0, 600);
    total++; if (n_acc !== 144) begin bad++; $display("FAIL clamp_count: got %0d want 144", n_acc); end
    if (n_acc == 144) begin
      total++; if (got_clamp[0] !== exp_c0) begin bad++; $display("FAIL clamp_e1: got %h want %h", got_clamp[0], exp_c0); end
      total++; if (got_clamp[2] !== exp_c2) begin bad++; $display("FAIL clamp_e3: got %h want %h", got_clamp[2], exp_c2); end
      total++; if (got_clamp[4] !== exp_c4) begin bad++; $display("FAIL clamp_e5: got %h want %h", got_clamp[4], exp_c4); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_multichannel();
    test_backpressure();
    test_zero_restart();
    test_reset_midjob();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/im2col_addr_gen.md
Name: im2col_addr_gen

Overview:
- Parametrised im2col address generator for the convolution datapath. Successor to the divider-based address converter.
- Walks output windows, channels and kernel offsets with internal nested counters, so it needs no external Bx/By index stream and no dividers.
- Emits one byte address per accepted element over a valid/ready handshake, and flags padding elements with a pad-address marker.
- Sits between layer config registers and the DMA request queue.

Parameters:
- ADDR_W, 32, address and base width.
- DIM_W, 8, width of image height/width and output dimension fields.
- CH_W, 10, width of channel count.
- ELEM_LOG2, 2, log2 of element size in bytes (address = element index << ELEM_LOG2).
- PAD_ADDR, 32'h0000_0FFF, address emitted for out-of-range (padding) elements.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous assert, active-low.
- start, input, 1, one-cycle pulse; latches all cfg_* inputs.
- cfg_image_addr, input, ADDR_W, base address of channel 0, row 0, col 0.
- cfg_image_h, input, DIM_W, input rows.
- cfg_image_w, input, DIM_W, input columns.
- cfg_num_ch, input, CH_W, channels.
- cfg_ksize, input, 4, kernel side.
- cfg_stride, input, 4, stride.
- cfg_pad, input, 2, symmetric zero pad.
- cfg_out_h, input, DIM_W, output rows.
- cfg_out_w, input, DIM_W, output columns.
- addr_valid, output, 1, addr/addr_pad/addr_last valid.
- addr_ready, input, 1, consumer accepts.
- addr, output, ADDR_W, element byte address.
- addr_pad, output, 1, element is padding (addr==PAD_ADDR).
- addr_last, output, 1, final element of the job.
- addr_clamp, output, ADDR_W, clamped address (optional feature).
- busy, output, 1, job in progress.
- done, output, 1, one-cycle pulse after last element is accepted.

Behaviour:
- Reset: state IDLE; all outputs 0; counters and pipeline registers cleared. Reset mid-job aborts immediately; no done pulse.
- FSM:
  - IDLE: start → RUN, busy=1. If any of ksize, num_ch, out_h, out_w is 0, go to FINISH instead.
  - RUN: counters advance once per pipeline step. After the final counter value enters the pipe → DRAIN.
  - DRAIN: when the element with addr_last is accepted → FINISH.
  - FINISH: done=1 for one cycle, busy=0, → IDLE.
  - start outside IDLE is ignored.
- Loop order, outermost to innermost: oy (0..out_h-1), ox, c (0..num_ch-1), ky (0..ksize-1), kx.
- Coordinates: iy = oy*stride + ky - pad and ix = ox*stride + kx - pad, computed signed at DIM_W+6 bits.
- Out of range when iy<0, ix<0, iy>=image_h or ix>=image_w. Then addr=PAD_ADDR and addr_pad=1.
- Otherwise addr = cfg_image_addr + (((c*image_h + iy)*image_w + ix) << ELEM_LOG2), truncated to ADDR_W (wraps modulo 2^ADDR_W).
- Pipeline: 3 stages (counter → coordinate/range → address register). The first addr_valid rises 3 cycles after the start cycle.
- Handshake:
  - Transfer occurs when addr_valid && addr_ready.
  - While addr_valid && !addr_ready, the whole pipeline and counters freeze, and addr/addr_pad/addr_last hold stable.
  - addr_valid never drops without a transfer.
  - Pipeline bubbles are collapsed: stall applies only to occupied stages.
- Throughput: one element per cycle with addr_ready held high. Total elements = out_h*out_w*num_ch*ksize².
- addr_last=1 only on element (out_h-1, out_w-1, num_ch-1, k-1, k-1).
- Config inputs are sampled only at start; changes during a job have no effect.

Optional Feature:
- Macro: IM2COL_CLAMP_ADDR_EN.
- Defined:
  - addr_clamp carries the address computed with iy clamped to [0,image_h-1] and ix clamped to [0,image_w-1]. It is always a legal memory address, used for burst prefetch.
  - addr_clamp is registered in the same stage and has the same latency and stall as addr.
- Undefined: addr_clamp is tied to 0 and no clamp logic is built.

Test Plan:
- Basic stream. Config: base 0x1000, H=W=4, ch=1, k=3, stride 1, pad 0, out 2x2, ready high.
  - Expect 36 addresses.
  - First three are 0x1000, 0x1004, 0x1008; the 4th is 0x1010.
  - Last is 0x103C with addr_last=1.
  - done pulses one cycle after the last acceptance.
- Padding. Same config with pad=1, out 4x4.
  - Elements 1–4 are PAD_ADDR with addr_pad=1 (element 4 is ky=1,kx=0).
  - Element 5 (ky=1,kx=1) is 0x1000 with addr_pad=0.
  - Total 144 elements.
- Multichannel. ch=2, H=W=4, k=1, out 1x1.
  - Addresses are 0x1000, then 0x1040 with addr_last=1.
- Backpressure. Basic config; drop ready for 5 cycles after element 10.
  - addr holds 0x...; element 11 is stable throughout the stall.
  - No loss or duplication; still 36 elements in order.
- Zero config and ignored restart.
  - ksize=0: done pulses with no addr_valid.
  - start pulsed while busy: ignored, and the stream is unchanged.
- Reset mid-job. Assert rst at element 20.
  - All outputs 0 asynchronously and busy=0, with no done pulse.
  - A new start then replays from 0x1000.
- Clamp (with IM2COL_CLAMP_ADDR_EN defined, pad=1 config).
  - Element 1 has addr_clamp=0x1000.
  - Without the macro, addr_clamp stays 0.
